// File: rtl/ahb_slv_pkg.sv
// Shared encodings, FSM state type and byte-lane helper for the AHB-Lite memory responder.
package ahb_slv_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  typedef enum logic {READ, WRITE} tr_type_t;

  // Little-endian byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << offs;
      HSIZE_HALF: lane_mask = offs[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slv_ram.sv
// Word-organised synchronous RAM: registered read port that holds its value when
// not enabled, byte-enabled write port. No reset on contents or read data.
module ahb_slv_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [DEPTH];

  // A read to the word being written returns the old contents; the top merges new lanes.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder in front of an on-chip RAM: pipelined address/data phases,
// fixed wait states on OKAY transfers, two-cycle ERROR for illegal accesses.
module ahb_slave_mem import ahb_slv_pkg::*; #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output state_t                fsm_state
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
  localparam logic [2:0] WLAST   = 3'(WAIT_STATES);
  localparam logic [2:0] WPRE    = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic       NO_WAIT = (WAIT_STATES == 0);

  state_t        state, state_next;
  logic [2:0]    wcnt, wcnt_next;
  logic          ready_int;
  logic          accept, legal;

  logic          dp_valid;
  tr_type_t      dp_dir;
  logic [2:0]    dp_size;
  logic [AW+1:0] dp_addr;

  logic          wr_en, rd_now, rd_late, rd_issue, byp_hit;
  logic [3:0]    wr_mask, ram_we;
  logic [AW-1:0] raddr, waddr;
  logic [31:0]   ram_rdata;

  logic          rd_fresh;
  logic [3:0]    byp_mask;
  logic [31:0]   byp_data;
  logic [DATA_WIDTH-1:0] hrdata_q;

  // Data phase is extended in ERR1 and in every WAIT cycle before the last.
  assign ready_int = !((state == S_ERR1) || ((state == S_WAIT) && (wcnt != WLAST)));
  assign hreadyout = ready_int;
  assign fsm_state = state;

  assign accept = hsel && hready && ready_int &&
                  ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign legal  = ({1'b0, haddr} < MEM_BYTES) && (hsize <= HSIZE_WORD) &&
                  !((hsize == HSIZE_HALF) && haddr[0]) &&
                  !((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    hresp      = HRESP_OKAY;
    case (state)
      S_WAIT: if (wcnt != WLAST) wcnt_next = wcnt + 3'd1;
      S_ERR1: begin
        hresp      = HRESP_ERROR;
        state_next = S_ERR2;
      end
      S_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
    // Every cycle with hreadyout high is a transfer boundary: pick the next phase.
    if (ready_int) begin
      wcnt_next = 3'd0;
      if (accept && !legal)        state_next = S_ERR1;
      else if (accept && !NO_WAIT) state_next = S_WAIT;
      else                         state_next = S_IDLE;
    end
  end

  assign wr_mask  = lane_mask(dp_size, dp_addr[1:0]);
  assign wr_en    = hreset && dp_valid && (dp_dir == WRITE) && ready_int;
  assign ram_we   = wr_en ? wr_mask : 4'b0000;
  assign waddr    = dp_addr[AW+1:2];

  // Zero-wait reads fetch at the accepting edge; waited reads one edge before completion.
  assign rd_now   = NO_WAIT && accept && legal && !hwrite;
  assign rd_late  = !NO_WAIT && (state == S_WAIT) && dp_valid && (dp_dir == READ) &&
                    (wcnt == WPRE);
  assign rd_issue = hreset && (rd_now || rd_late);
  assign raddr    = rd_now ? haddr[AW+1:2] : dp_addr[AW+1:2];
  assign byp_hit  = wr_en && rd_issue && (raddr == waddr);

  ahb_slv_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk   (hclk),
    .re    (rd_issue),
    .raddr (raddr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (hwdata[31:0])
  );

  always_ff @(posedge hclk) begin
    if (!hreset) begin
      state    <= S_IDLE;
      wcnt     <= 3'd0;
      dp_valid <= 1'b0;
      dp_dir   <= READ;
      dp_size  <= HSIZE_WORD;
      dp_addr  <= '0;
      rd_fresh <= 1'b0;
      byp_mask <= 4'b0000;
      byp_data <= 32'd0;
      hrdata_q <= '0;
    end else begin
      state    <= state_next;
      wcnt     <= wcnt_next;
      if (ready_int) begin
        dp_valid <= accept && legal;
        if (accept) begin
          dp_dir  <= hwrite ? WRITE : READ;
          dp_size <= hsize;
          dp_addr <= haddr[AW+1:0];
        end
      end
      rd_fresh <= rd_issue;
      if (rd_issue) begin
        byp_mask <= byp_hit ? wr_mask : 4'b0000;
        byp_data <= hwdata[31:0];
      end
      hrdata_q <= hrdata;
    end
  end

  // Fresh read data overlays lanes written at the fetch edge; otherwise hold.
  always_comb begin
    hrdata = hrdata_q;
    if (rd_fresh) begin
      for (int i = 0; i < 4; i++) begin
        hrdata[8*i +: 8] = byp_mask[i] ? byp_data[8*i +: 8] : ram_rdata[8*i +: 8];
      end
    end
  end

endmodule
